// File: rtl/count_mod_bcd.sv
// rtl/count_mod_bcd.sv - modulo-N tick counter with registered two-digit BCD display
// Serves hours/minutes/seconds stages; carry_o chains into the next stage's tick_i.
module count_mod_bcd #(
  parameter int MODULUS = 24,
  parameter int IVAL    = 0,
  parameter int CW      = $clog2(MODULUS)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          tick_i,
  input  logic          dec_i,
  input  logic          load_i,
  input  logic [CW-1:0] lval_i,
  input  logic          mode12_i,
  output logic [CW-1:0] count_o,
  output logic [3:0]    segment0_o,
  output logic [3:0]    segment1_o,
  output logic          pm_o,
  output logic          carry_o
);

  localparam logic [CW-1:0] MAX_C  = CW'(MODULUS - 1);
  localparam logic [CW-1:0] IVAL_C = CW'(IVAL);
  localparam logic [CW:0]   MOD_W  = (CW + 1)'(MODULUS);
  localparam bit            HOURS  = (MODULUS == 24);

  logic [CW-1:0] next_count;
  logic          next_carry;
  logic [CW-1:0] shown;
  logic [7:0]    raw;
  logic [7:0]    val;
  logic [3:0]    seg0_d;
  logic [3:0]    seg1_d;
  logic          pm_d;

  always_comb begin
    next_count = count_o;
    next_carry = 1'b0;
    if (load_i) begin
      next_count = ({1'b0, lval_i} < MOD_W) ? lval_i : '0;
    end else if (tick_i && dec_i) begin
      next_count = count_o;
    end else if (tick_i) begin
      if (count_o == MAX_C) begin
        next_count = '0;
        next_carry = 1'b1;
      end else begin
        next_count = count_o + CW'(1);
      end
    end else if (dec_i) begin
      next_count = (count_o == '0) ? MAX_C : count_o - CW'(1);
    end
  end

  // Display follows the value the count register is about to take, so the
  // binary and BCD views always change on the same edge.
  always_comb begin
    shown = rstn_i ? next_count : IVAL_C;
    raw   = 8'(shown);
    val   = raw;
    pm_d  = 1'b0;
    if (HOURS && mode12_i) begin
      val  = 8'(raw % 8'd12);
      if (val == 8'd0) val = 8'd12;
      pm_d = (raw >= 8'd12);
    end
    seg1_d = 4'(val / 8'd10);
    seg0_d = 4'(val % 8'd10);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_o <= IVAL_C;
      carry_o <= 1'b0;
    end else begin
      count_o <= next_count;
      carry_o <= next_carry;
    end
    segment0_o <= seg0_d;
    segment1_o <= seg1_d;
    pm_o       <= pm_d;
  end

endmodule

// File: tb/tb_count_mod_bcd.sv
// tb/tb_count_mod_bcd.sv - bench for count_mod_bcd with three instances sharing one stimulus
// Instances: a = MOD 24/IVAL 22, b = MOD 60/IVAL 0, c = MOD 24/IVAL 5.
module tb_count_mod_bcd;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick = 1'b0;
  logic       dec = 1'b0;
  logic       load = 1'b0;
  logic       mode12 = 1'b0;
  logic [7:0] lval = 8'd0;

  logic [4:0] cnt_a, cnt_c;
  logic [5:0] cnt_b;
  logic [3:0] s0_a, s1_a, s0_b, s1_b, s0_c, s1_c;
  logic       pm_a, pm_b, pm_c, car_a, car_b, car_c;

  int total = 0;
  int passes = 0;
  bit mv = 1'b0;

  int modv[3]  = '{24, 60, 24};
  int ivalv[3] = '{22, 0, 5};
  int cwv[3]   = '{5, 6, 5};
  int mcnt[3], mcar[3], ms0[3], ms1[3], mpm[3];

  always #5 clk = ~clk;

  count_mod_bcd #(.MODULUS(24), .IVAL(22)) u_a (
    .clk_i(clk), .rstn_i(rstn), .tick_i(tick), .dec_i(dec), .load_i(load),
    .lval_i(lval[4:0]), .mode12_i(mode12), .count_o(cnt_a), .segment0_o(s0_a),
    .segment1_o(s1_a), .pm_o(pm_a), .carry_o(car_a));

  count_mod_bcd #(.MODULUS(60), .IVAL(0)) u_b (
    .clk_i(clk), .rstn_i(rstn), .tick_i(tick), .dec_i(dec), .load_i(load),
    .lval_i(lval[5:0]), .mode12_i(mode12), .count_o(cnt_b), .segment0_o(s0_b),
    .segment1_o(s1_b), .pm_o(pm_b), .carry_o(car_b));

  count_mod_bcd #(.MODULUS(24), .IVAL(5)) u_c (
    .clk_i(clk), .rstn_i(rstn), .tick_i(tick), .dec_i(dec), .load_i(load),
    .lval_i(lval[4:0]), .mode12_i(mode12), .count_o(cnt_c), .segment0_o(s0_c),
    .segment1_o(s1_c), .pm_o(pm_c), .carry_o(car_c));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: the count as a plain integer, display derived from decimal arithmetic.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int lv, h;
      lv = int'(lval) % (1 << cwv[i]);
      mcar[i] = 0;
      if (!rstn) mcnt[i] = ivalv[i];
      else if (load) mcnt[i] = (lv < modv[i]) ? lv : 0;
      else if (tick && dec) mcnt[i] = mcnt[i];
      else if (tick) begin
        mcnt[i] = (mcnt[i] + 1) % modv[i];
        mcar[i] = (mcnt[i] == 0) ? 1 : 0;
      end else if (dec) mcnt[i] = (mcnt[i] + modv[i] - 1) % modv[i];
      if (modv[i] == 24 && mode12) begin
        h = mcnt[i] % 12;
        if (h == 0) h = 12;
        mpm[i] = (mcnt[i] >= 12) ? 1 : 0;
      end else begin
        h = mcnt[i];
        mpm[i] = 0;
      end
      ms1[i] = h / 10;
      ms0[i] = h % 10;
    end
    if (!rstn) mv = 1'b1;
  end

  task automatic cmp(input int i, input int c, input int s0, input int s1, input int pm, input int cy);
    chk($sformatf("count%0d", i), c, mcnt[i]);
    chk($sformatf("seg0_%0d", i), s0, ms0[i]);
    chk($sformatf("seg1_%0d", i), s1, ms1[i]);
    chk($sformatf("pm%0d", i), pm, mpm[i]);
    chk($sformatf("carry%0d", i), cy, mcar[i]);
  endtask

  always @(negedge clk) begin
    if (mv) begin
      cmp(0, int'(cnt_a), int'(s0_a), int'(s1_a), int'(pm_a), int'(car_a));
      cmp(1, int'(cnt_b), int'(s0_b), int'(s1_b), int'(pm_b), int'(car_b));
      cmp(2, int'(cnt_c), int'(s0_c), int'(s1_c), int'(pm_c), int'(car_c));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ncar, max0, max1;
    cyc(); cyc();
    chk("rst_a_cnt", int'(cnt_a), 22);
    chk("rst_a_seg", int'({s1_a, s0_a}), 8'h22);
    chk("rst_a_carry", int'(car_a), 0);
    chk("rst_b_cnt", int'(cnt_b), 0);
    chk("rst_c_cnt", int'(cnt_c), 5);

    rstn = 1'b1; tick = 1'b1;
    cyc(); chk("t1_cnt", int'(cnt_a), 23); chk("t1_seg", int'({s1_a, s0_a}), 8'h23);
    chk("t1_carry", int'(car_a), 0);
    cyc(); chk("t2_cnt", int'(cnt_a), 0); chk("t2_seg", int'({s1_a, s0_a}), 8'h00);
    chk("t2_carry", int'(car_a), 1);
    cyc(); chk("t3_cnt", int'(cnt_a), 1); chk("t3_seg", int'({s1_a, s0_a}), 8'h01);
    chk("t3_carry", int'(car_a), 0);
    tick = 1'b0;

    rstn = 1'b0; cyc(); rstn = 1'b1;
    ncar = 0; max0 = 0; max1 = 0;
    for (int i = 0; i < 180; i++) begin
      tick = (i % 3 == 0);
      cyc();
      if (car_b) ncar++;
      if (int'(s0_b) > max0) max0 = int'(s0_b);
      if (int'(s1_b) > max1) max1 = int'(s1_b);
    end
    tick = 1'b0;
    chk("m60_carries", ncar, 1);
    chk("m60_end_cnt", int'(cnt_b), 0);
    chk("m60_max_seg0", max0, 9);
    chk("m60_max_seg1", max1, 5);

    mode12 = 1'b1; load = 1'b1; lval = 8'd0;
    cyc(); load = 1'b0;
    chk("h12_0_seg", int'({s1_a, s0_a}), 8'h12); chk("h12_0_pm", int'(pm_a), 0);
    tick = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (k == 11) begin
        chk("h12_11_seg", int'({s1_a, s0_a}), 8'h11); chk("h12_11_pm", int'(pm_a), 0);
      end else if (k == 12) begin
        chk("h12_12_seg", int'({s1_a, s0_a}), 8'h12); chk("h12_12_pm", int'(pm_a), 1);
      end else if (k == 13) begin
        chk("h12_13_seg", int'({s1_a, s0_a}), 8'h01); chk("h12_13_pm", int'(pm_a), 1);
      end
    end
    tick = 1'b0; mode12 = 1'b0;
    cyc(); chk("h24_15_seg", int'({s1_a, s0_a}), 8'h15); chk("h24_15_pm", int'(pm_a), 0);
    mode12 = 1'b1;
    cyc(); chk("h12_15_seg", int'({s1_a, s0_a}), 8'h03); chk("h12_15_pm", int'(pm_a), 1);
    tick = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("h12_23_seg", int'({s1_a, s0_a}), 8'h11); chk("h12_23_pm", int'(pm_a), 1);
    tick = 1'b0; mode12 = 1'b0;

    load = 1'b1; lval = 8'd0; cyc(); load = 1'b0;
    dec = 1'b1; cyc();
    chk("dec_cnt", int'(cnt_a), 23); chk("dec_seg", int'({s1_a, s0_a}), 8'h23);
    chk("dec_carry", int'(car_a), 0);
    tick = 1'b1; cyc();
    chk("tickdec_cnt", int'(cnt_a), 23); chk("tickdec_carry", int'(car_a), 0);
    tick = 1'b0; dec = 1'b0;

    load = 1'b1; lval = 8'd17; cyc();
    chk("ld17_cnt", int'(cnt_a), 17); chk("ld17_seg", int'({s1_a, s0_a}), 8'h17);
    lval = 8'd30; cyc();
    chk("ld30_cnt_a", int'(cnt_a), 0); chk("ld30_cnt_b", int'(cnt_b), 30);
    lval = 8'd23; cyc();
    lval = 8'd17; tick = 1'b1; cyc();
    chk("ldwrap_cnt", int'(cnt_a), 17); chk("ldwrap_carry", int'(car_a), 0);
    load = 1'b0; tick = 1'b0;

    load = 1'b1; lval = 8'd23; cyc(); load = 1'b0;
    chk("pre_rst_c", int'(cnt_c), 23);
    tick = 1'b1; rstn = 1'b0; cyc();
    chk("rstmid_cnt", int'(cnt_c), 5); chk("rstmid_seg", int'({s1_c, s0_c}), 8'h05);
    chk("rstmid_carry", int'(car_c), 0);
    rstn = 1'b1; cyc();
    chk("resume_cnt", int'(cnt_c), 6);
    tick = 1'b0; cyc(); cyc();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/count_mod_bcd.md
# count_mod_bcd

Parametrised modulo-N counter with two-digit BCD outputs. It is the generic successor of the fixed 0–23 hour counter and serves the hours, minutes and seconds stages of the watch. It advances on a one-cycle tick enable, so the whole chain runs on one system clock. It also supports user adjustment (increment, decrement, direct load), an optional 12-hour display mode for the hours stage, and a carry pulse that chains to the next stage.

## Interface
Parameters:
- MODULUS, default 24: count range 0..MODULUS-1. Legal values are 2..100.
- IVAL, default 0: reset value. Must be < MODULUS.
- CW, default $clog2(MODULUS): width of the binary count and the load value. Derived; never overridden.

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- rstn_i  in  1  one clock; reset is synchronous and active-low.
- tick_i  in  1  advance by +1 this cycle (one-cycle pulse, normally the previous stage's carry_o).
- dec_i  in  1  step by −1 this cycle (user adjust).
- load_i  in  1  load lval_i this cycle.
- lval_i  in  CW  binary load value.
- mode12_i  in  1  12-hour display select; honoured only when MODULUS == 24, ignored otherwise.
- count_o  out  CW  registered binary count.
- segment0_o  out  4  registered BCD units digit.
- segment1_o  out  4  registered BCD tens digit.
- pm_o  out  1  registered; 1 when 12-hour mode is active and count ≥ 12.
- carry_o  out  1  registered one-cycle pulse on the tick-driven wrap from MODULUS-1 to 0.

## Operation
Update priority, evaluated each rising edge:
- rstn_i = 0: count ← IVAL, carry_o ← 0. Display registers take the value for IVAL, using mode12_i as sampled at that edge.
- else load_i = 1: count ← lval_i when lval_i < MODULUS, otherwise count ← 0. carry_o ← 0. tick_i and dec_i are ignored that cycle.
- else tick_i = 1 and dec_i = 1: count unchanged, carry_o ← 0.
- else tick_i = 1: if count == MODULUS-1 then count ← 0 and carry_o ← 1; otherwise count ← count+1 and carry_o ← 0.
- else dec_i = 1: if count == 0 then count ← MODULUS-1, otherwise count ← count-1. carry_o ← 0. There is no borrow output.
- else: count holds, carry_o ← 0.

Display (registered each cycle from next-count and the current mode12_i):
- 24-hour or non-hours mode:
  - segment1_o = next-count / 10.
  - segment0_o = next-count mod 10.
  - pm_o = 0.
- 12-hour mode (MODULUS == 24 and mode12_i = 1):
  - h = next-count mod 12; a value of 0 is shown as 12.
  - segment1_o/segment0_o = BCD of that value.
  - pm_o = (next-count ≥ 12).
- segment1_o[3:2] is 0 whenever MODULUS ≤ 40. No BCD digit ever exceeds 9.
- Arithmetic is unsigned, CW bits. The wrap compare uses MODULUS-1 exactly. The count never leaves 0..MODULUS-1.

## Timing
- Latency: an event applied at edge k is visible on count_o, the segments, pm_o and carry_o immediately after edge k. All outputs change together; there is no skew between the binary and BCD views.
- carry_o is high for exactly the one cycle following the wrapping edge. Back-to-back ticks at MODULUS-1 and then 0 give a single carry pulse.
- A mode12_i change is reflected after the next edge, even if the count is idle.
- Reset mid-operation: the next edge forces the reset state regardless of tick_i, dec_i or load_i. A carry_o pulse pending in that cycle is cleared.
- Reset values: count_o = IVAL; segments = BCD(IVAL) per mode; pm_o per mode; carry_o = 0.
- Simultaneous load and wrap: load wins and no carry is produced.

## Test plan
- MODULUS=24, IVAL=22, 24-hour mode, tick_i every cycle:
  - counts 22, 23, 0, 1.
  - segments 2/2, 2/3, 0/0, 0/1.
  - carry_o = 1 only in the cycle after 23→0.
- MODULUS=60, tick_i pulsed every 3 cycles from 0:
  - 180 cycles give exactly one carry_o, at 59→0.
  - segment0_o steps 0..9 and segment1_o steps 0..5; no digit ever exceeds 9.
- MODULUS=24, mode12_i=1, tick_i sweep from 0:
  - count 0 → 1/2, pm 0.
  - count 11 → 1/1, pm 0.
  - count 12 → 1/2, pm 1.
  - count 13 → 0/1, pm 1.
  - count 23 → 1/1, pm 1.
  - Toggling mode12_i at count 15 switches the display from 1/5 to 0/3 one cycle later.
- dec_i at count 0, MODULUS=24 → count 23, segments 2/3, carry_o stays 0.
  - tick_i and dec_i together at count 23 → count 23, no carry.
- load_i with lval_i=17, MODULUS=24 → count 17, segments 1/7.
  - lval_i=30 → count 0.
  - load_i and tick_i together at count 23 → loaded value taken, carry_o 0.
- Count reaches 23 and tick_i is asserted in the same cycle rstn_i=0 (IVAL=5):
  - count 5, segments 0/5, carry_o 0 after that edge.
  - Counting resumes from 5 once rstn_i=1.
